// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: XLEN, instruction size,
// sequencer states and the instruction-buffer entry layout.
package fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FAULT
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } buf_entry_t;

   function automatic logic is_aligned(input logic [XLEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered storage, occupancy count and flush.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: issues in-order I-mem requests under a credit limit,
// buffers returned instructions for decode and squashes wrong-path traffic.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH       = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_addr,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_instr,
   output logic            out_valid,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_plus4,
   input  logic            out_ready,
   output logic            fault_valid,
   output logic [XLEN-1:0] fault_addr
);

   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

   fetch_state_e    state;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] fault_addr_q;
   logic [OUT_W-1:0] outstanding;
   logic [OUT_W-1:0] stale_cnt;
   logic [OCC_W-1:0] occupancy;
   logic [XLEN-1:0] pcq_head;
   buf_entry_t      buf_head;
   buf_entry_t      buf_in;
   logic            req_fire;
   logic            drop_resp;
   logic            buf_push;
   logic            buf_pop;

   // Credit check uses only registered counts so redirect never reaches the request port.
   assign imem_req_valid = (state == RUN)
                         && (32'(outstanding) < MAX_OUTSTANDING)
                         && (32'(outstanding) + 32'(occupancy) < BUF_DEPTH);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign drop_resp = redirect_valid || (stale_cnt != '0);
   assign buf_push  = imem_resp_valid && !drop_resp;
   assign buf_pop   = out_valid && out_ready && !redirect_valid;
   assign buf_in    = '{pc: pcq_head, instr: imem_resp_instr};

   assign out_valid    = (state == RUN) && (occupancy != '0);
   assign out_instr    = out_valid ? buf_head.instr : '0;
   assign out_pc       = out_valid ? buf_head.pc : '0;
   assign out_pc_plus4 = out_valid ? buf_head.pc + XLEN'(INSTR_BYTES) : '0;
   assign fault_valid  = (state == FAULT);
   assign fault_addr   = fault_addr_q;

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTSTANDING)
   ) u_pc_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (req_fire),
      .push_data (pc_q),
      .pop       (imem_resp_valid),
      .head      (pcq_head),
      .count     (outstanding)
   );

   fetch_fifo #(
      .WIDTH ($bits(buf_entry_t)),
      .DEPTH (BUF_DEPTH)
   ) u_instr_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (buf_push),
      .push_data (buf_in),
      .pop       (buf_pop),
      .head      (buf_head),
      .count     (occupancy)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= BOOT;
         pc_q         <= RESET_PC;
         stale_cnt    <= '0;
         fault_addr_q <= '0;
      end else if (redirect_valid) begin
         // Everything in flight after this edge is wrong-path, including this cycle's accept.
         stale_cnt <= outstanding + OUT_W'(req_fire) - OUT_W'(imem_resp_valid);
         if (is_aligned(redirect_addr)) begin
            pc_q  <= redirect_addr;
            state <= RUN;
         end else begin
            if (state != FAULT) begin
               fault_addr_q <= redirect_addr;
            end
            state <= FAULT;
         end
      end else begin
         if (state == BOOT) begin
            state <= RUN;
         end
         if (req_fire) begin
            pc_q <= pc_q + XLEN'(INSTR_BYTES);
         end
         if (imem_resp_valid && (stale_cnt != '0)) begin
            stale_cnt <= stale_cnt - OUT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic against an epoch-tagged stream model.
module tb_fetch_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned MAXO   = 2;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_instr;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        out_ready;
   logic        fault_valid;
   logic [31:0] fault_addr;

   fetch_sequencer #(
      .RESET_PC        (RST_PC),
      .BUF_DEPTH       (DEPTH),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_addr   (redirect_addr),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_instr (imem_resp_instr),
      .out_valid       (out_valid),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .out_pc_plus4    (out_pc_plus4),
      .out_ready       (out_ready),
      .fault_valid     (fault_valid),
      .fault_addr      (fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned epoch;
      int unsigned due;
   } mreq_t;

   typedef struct {
      logic        redir;
      logic [31:0] raddr;
      logic        req_ready;
      logic        out_ready;
      logic        e_req_valid;
      logic [31:0] e_req_addr;
      logic        e_out_valid;
      logic [31:0] e_out_pc;
      logic [31:0] e_plus4;
      logic        e_fault;
      logic [31:0] e_fault_addr;
   } vec_t;

   vec_t        tv [15];
   mreq_t       memq [$];
   logic [31:0] obuf [$];
   logic [31:0] delivered [$];
   logic [31:0] acc_log [$];
   logic [31:0] resp_log [$];

   int unsigned epoch, cyc, n_cmp, n_err, n_deliv;
   logic        m_boot, m_fault;
   logic [31:0] m_pc, m_fault_addr;
   logic        mem_hold, mem_rand;
   logic        k_redir, k_req_ready, k_out_ready;
   logic [31:0] k_raddr;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      memq.delete();
      obuf.delete();
      delivered.delete();
      acc_log.delete();
      resp_log.delete();
      epoch++;
      m_boot       = 1'b1;
      m_fault      = 1'b0;
      m_fault_addr = '0;
      m_pc         = RST_PC;
   endtask

   // Called at a negedge: check, drive, advance one clock, update the model.
   task automatic cycle();
      logic        s_req_valid, s_out_valid, exp_req, exp_out, accept, resp, hs;
      logic [31:0] s_req_addr;
      mreq_t       e;
      exp_req = !m_boot && !m_fault && (memq.size() < int'(MAXO))
                && (memq.size() + obuf.size() < int'(DEPTH));
      exp_out = !m_fault && (obuf.size() != 0);
      chk("m_req_valid", 32'(imem_req_valid), 32'(exp_req));
      chk("m_req_addr", imem_req_addr, m_pc);
      chk("m_out_valid", 32'(out_valid), 32'(exp_out));
      if (exp_out) begin
         chk("m_out_pc", out_pc, obuf[0]);
         chk("m_out_instr", out_instr, mem_fn(obuf[0]));
         chk("m_out_pc_plus4", out_pc_plus4, obuf[0] + 32'd4);
      end
      chk("m_fault_valid", 32'(fault_valid), 32'(m_fault));
      if (m_fault) chk("m_fault_addr", fault_addr, m_fault_addr);
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_out_valid = out_valid;

      redirect_valid = k_redir;
      redirect_addr  = k_raddr;
      imem_req_ready = k_req_ready;
      out_ready      = k_out_ready;
      resp = !mem_hold && (memq.size() != 0) && (memq[0].due <= cyc)
             && (!mem_rand || ($urandom_range(0, 9) < 6));
      imem_resp_valid = resp;
      imem_resp_instr = resp ? mem_fn(memq[0].addr) : $urandom;

      @(posedge clk);
      accept = s_req_valid && k_req_ready;
      hs     = s_out_valid && k_out_ready;
      if (hs && !k_redir && (obuf.size() != 0)) begin
         delivered.push_back(obuf[0]);
         n_deliv++;
         void'(obuf.pop_front());
      end
      if (resp) begin
         e = memq.pop_front();
         resp_log.push_back(e.addr);
         if (!k_redir && (e.epoch == epoch)) obuf.push_back(e.addr);
      end
      if (accept) begin
         memq.push_back('{addr: s_req_addr, epoch: epoch, due: cyc + 1});
         acc_log.push_back(s_req_addr);
      end
      if (k_redir) begin
         obuf.delete();
         epoch++;
         if (k_raddr[1:0] == 2'b00) begin
            m_pc    = k_raddr;
            m_fault = 1'b0;
         end else begin
            if (!m_fault) m_fault_addr = k_raddr;
            m_fault = 1'b1;
         end
      end else if (accept) begin
         m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic redirect_cycle(input logic [31:0] addr);
      k_redir = 1'b1;
      k_raddr = addr;
      cycle();
      k_redir = 1'b0;
      k_raddr = '0;
   endtask

   task automatic do_reset();
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b0;
      out_ready       = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_pc_plus4", out_pc_plus4, 32'd0);
      chk("rst_fault_valid", 32'(fault_valid), 32'd0);
      chk("rst_fault_addr", fault_addr, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] first;
      int unsigned below, deliv0, r;

      //   redir  raddr          rr    ordy  | rv    req_addr       ov    out_pc         plus4          f     fault_addr
      tv[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h100,       1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      tv[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      tv[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h104,       1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      tv[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h108,       1'b1, 32'h100,       32'h104,       1'b0, 32'h0};
      tv[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h108,       1'b1, 32'h104,       32'h108,       1'b0, 32'h0};
      tv[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h10C,       1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      tv[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h10C,       1'b1, 32'h108,       32'h10C,       1'b0, 32'h0};
      tv[7]  = '{1'b1, 32'h2002,      1'b0, 1'b1, 1'b1, 32'h10C,       1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      tv[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h10C,       1'b0, 32'h0,         32'h0,         1'b1, 32'h2002};
      tv[9]  = '{1'b1, 32'h3000,      1'b1, 1'b1, 1'b0, 32'h10C,       1'b0, 32'h0,         32'h0,         1'b1, 32'h2002};
      tv[10] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 32'h3000,      1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      tv[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      tv[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      tv[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h0};
      tv[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h0};

      rst = 1'b0;
      redirect_valid = 1'b0;  redirect_addr = '0;
      imem_req_ready = 1'b0;  imem_resp_valid = 1'b0;  imem_resp_instr = '0;
      out_ready = 1'b0;
      epoch = 0; cyc = 0; n_cmp = 0; n_err = 0; n_deliv = 0;
      mem_hold = 1'b0; mem_rand = 1'b0;
      k_redir = 1'b0; k_raddr = '0; k_req_ready = 1'b0; k_out_ready = 1'b0;

      @(negedge clk);
      do_reset();

      // Directed table: streaming, fault entry/exit, wrap-around at 2^32.
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("tv%0d_req_valid", i), 32'(imem_req_valid), 32'(tv[i].e_req_valid));
         chk($sformatf("tv%0d_req_addr", i), imem_req_addr, tv[i].e_req_addr);
         chk($sformatf("tv%0d_out_valid", i), 32'(out_valid), 32'(tv[i].e_out_valid));
         if (tv[i].e_out_valid) begin
            chk($sformatf("tv%0d_out_pc", i), out_pc, tv[i].e_out_pc);
            chk($sformatf("tv%0d_out_instr", i), out_instr, mem_fn(tv[i].e_out_pc));
            chk($sformatf("tv%0d_out_pc_plus4", i), out_pc_plus4, tv[i].e_plus4);
         end
         chk($sformatf("tv%0d_fault_valid", i), 32'(fault_valid), 32'(tv[i].e_fault));
         if (tv[i].e_fault) chk($sformatf("tv%0d_fault_addr", i), fault_addr, tv[i].e_fault_addr);
         k_redir     = tv[i].redir;
         k_raddr     = tv[i].raddr;
         k_req_ready = tv[i].req_ready;
         k_out_ready = tv[i].out_ready;
         cycle();
      end
      k_redir = 1'b0;

      // Decode backpressure: credit limit stops requests, nothing lost after release.
      do_reset();
      k_req_ready = 1'b1;
      k_out_ready = 1'b0;
      repeat (10) cycle();
      chk("bp_accepts", acc_log.size(), 32'd2);
      chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_pc", out_pc, RST_PC);
      k_out_ready = 1'b1;
      repeat (30) cycle();
      chk("bp_delivered_min", 32'(delivered.size() >= 8), 32'd1);
      foreach (delivered[i]) chk($sformatf("bp_order%0d", i), delivered[i], RST_PC + 32'(4 * i));

      // Redirect with two requests in flight.
      do_reset();
      mem_hold = 1'b1;
      for (int n = 0; n < 10 && memq.size() < 2; n++) cycle();
      chk("rd_outstanding", memq.size(), 32'd2);
      redirect_cycle(32'h2000);
      chk("rd_req_addr_next", imem_req_addr, 32'h2000);
      mem_hold = 1'b0;
      repeat (20) cycle();
      first = (delivered.size() != 0) ? delivered[0] : 32'hFFFF_FFFF;
      chk("rd_first_pc", first, 32'h2000);
      below = 0;
      foreach (delivered[i]) if (delivered[i] < 32'h2000) below++;
      chk("rd_wrong_path_delivered", below, 32'd0);

      // Redirect coinciding with a response and a request accept.
      do_reset();
      cycle();
      cycle();
      chk("sr_pre_outstanding", memq.size(), 32'd1);
      redirect_cycle(32'h4000);
      chk("sr_resp_in_redirect", resp_log.size(), 32'd1);
      chk("sr_accepts", acc_log.size(), 32'd2);
      repeat (20) cycle();
      first = (delivered.size() != 0) ? delivered[0] : 32'hFFFF_FFFF;
      chk("sr_first_pc", first, 32'h4000);
      first = (resp_log.size() > 2) ? resp_log[2] : 32'hFFFF_FFFF;
      chk("sr_one_stale_then_target", first, 32'h4000);

      // Reset in the middle of traffic, then restart from RESET_PC.
      repeat (3) cycle();
      do_reset();
      cycle();
      cycle();
      first = (acc_log.size() != 0) ? acc_log[0] : 32'hFFFF_FFFF;
      chk("rr_restart_addr", first, RST_PC);

      // Randomized traffic against the model.
      do_reset();
      mem_rand = 1'b1;
      deliv0 = n_deliv;
      for (int n = 0; n < 3000; n++) begin
         k_req_ready = ($urandom_range(0, 3) != 0);
         k_out_ready = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 99);
         if (r < 2) begin
            k_redir = 1'b1;
            k_raddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'h3);
         end else if (r < 3 && $urandom_range(0, 2) == 0) begin
            k_redir = 1'b1;
            k_raddr = ($urandom & ~32'h3) | 32'($urandom_range(1, 3));
         end
         if ($urandom_range(0, 999) == 0) do_reset();
         else cycle();
         k_redir = 1'b0;
      end
      chk("rand_liveness", 32'((n_deliv - deliv0) > 200), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
